// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: rounding mode codes, Q-format width arithmetic
// and extreme-code generators for the FXP datapath chain.
package fxp_pkg;

    localparam logic RND_TRUNC  = 1'b0;
    localparam logic RND_HALFUP = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned prod_int(input int unsigned a_i, input int unsigned b_i);
        return a_i + b_i;
    endfunction

    function automatic int unsigned prod_frac(input int unsigned a_f, input int unsigned b_f);
        return a_f + b_f;
    endfunction

    function automatic int unsigned sum_frac(input int unsigned p_f, input int unsigned c_f);
        return max_u(p_f, c_f);
    endfunction

    // One guard integer bit keeps the aligned sum exact.
    function automatic int unsigned sum_int(input int unsigned p_i, input int unsigned c_i);
        return max_u(p_i, c_i) + 1;
    endfunction

    // Low w bits hold the largest positive two's-complement code.
    function automatic logic [63:0] max_code(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_code(input int unsigned w);
        return ~max_code(w);
    endfunction

endpackage

// File: rtl/fxp_mac_pipe_if.sv
// Valid/ready bus for the fixed-point multiply-add: operand side and result side.
interface fxp_mac_pipe_if #(
    parameter int unsigned A_W = 6,
    parameter int unsigned B_W = 6,
    parameter int unsigned C_W = 10,
    parameter int unsigned Y_W = 7
);
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a_in;
    logic [B_W-1:0] b_in;
    logic [C_W-1:0] c_in;
    logic           rnd_mode;
    logic           sat_en;
    logic           out_valid;
    logic           out_ready;
    logic [Y_W-1:0] y_out;
    logic           ovf_out;

    modport master (
        output in_valid, a_in, b_in, c_in, rnd_mode, sat_en, out_ready,
        input  in_ready, out_valid, y_out, ovf_out
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, rnd_mode, sat_en, out_ready,
        output in_ready, out_valid, y_out, ovf_out
    );
endinterface

// File: rtl/fxp_quantize.sv
// Combinational requantiser: exact Q(SW-SF).(SF) sum to Q(OUT_I).(OUT_F) with
// floor or round-half-up, then saturate or wrap, flagging out-of-range results.
module fxp_quantize
    import fxp_pkg::*;
#(
    parameter int unsigned SW    = 14,
    parameter int unsigned SF    = 8,
    parameter int unsigned OUT_I = 5,
    parameter int unsigned OUT_F = 2
) (
    input  logic signed [SW-1:0]          sum,
    input  logic                          rnd_mode,
    input  logic                          sat_en,
    output logic        [OUT_I+OUT_F-1:0] y_c,
    output logic                          ovf_c
);
    localparam int unsigned Y_W  = OUT_I + OUT_F;
    localparam int unsigned PAD  = (OUT_F > SF) ? OUT_F - SF : 0;
    localparam int unsigned DROP = (SF > OUT_F) ? SF - OUT_F : 0;
    localparam int unsigned EW   = max_u(SW + 1 + PAD, Y_W + 1);

    logic signed [EW-1:0]  ext_c;
    logic signed [EW-1:0]  q_c;
    logic        [EW-Y_W:0] hi_c;

    assign ext_c = EW'(sum);

    if (DROP > 0) begin : g_drop
        localparam logic signed [EW-1:0] HALF = EW'(1) <<< (DROP - 1);
        logic signed [EW-1:0] bias_c;
        assign bias_c = (rnd_mode == RND_HALFUP) ? HALF : EW'(0);
        assign q_c    = (ext_c + bias_c) >>> DROP;
    end else begin : g_pad
        assign q_c = ext_c <<< PAD;
    end

    // In range only when every bit above the output sign bit copies it.
    assign hi_c  = q_c[EW-1:Y_W-1];
    assign ovf_c = !((&hi_c) || !(|hi_c));

    always_comb begin
        y_c = q_c[Y_W-1:0];
        if (ovf_c && sat_en) begin
            y_c = q_c[EW-1] ? Y_W'(min_code(Y_W)) : Y_W'(max_code(Y_W));
        end
    end
endmodule

// File: rtl/fxp_mac_pipe.sv
// Three-stage elastic fixed-point multiply-add Y = quantize(A*B + C):
// S1 exact product, S2 aligned exact sum, S3 quantised result.
module fxp_mac_pipe
    import fxp_pkg::*;
#(
    parameter int unsigned A_I   = 3,
    parameter int unsigned A_F   = 3,
    parameter int unsigned B_I   = 1,
    parameter int unsigned B_F   = 5,
    parameter int unsigned C_I   = 5,
    parameter int unsigned C_F   = 5,
    parameter int unsigned OUT_I = 5,
    parameter int unsigned OUT_F = 2
) (
    input logic          clk,
    input logic          rst,
    fxp_mac_pipe_if.slave bus
);
    localparam int unsigned C_W = C_I + C_F;
    localparam int unsigned PI  = prod_int(A_I, B_I);
    localparam int unsigned PF  = prod_frac(A_F, B_F);
    localparam int unsigned PW  = PI + PF;
    localparam int unsigned SF  = sum_frac(PF, C_F);
    localparam int unsigned SW  = sum_int(PI, C_I) + SF;
    localparam int unsigned Y_W = OUT_I + OUT_F;

    logic                  s1_valid, s1_rnd, s1_sat;
    logic signed [PW-1:0]  s1_p;
    logic signed [C_W-1:0] s1_c;
    logic                  s2_valid, s2_rnd, s2_sat;
    logic signed [SW-1:0]  s2_sum;
    logic                  s3_valid, s3_ovf;
    logic        [Y_W-1:0] s3_y;

    logic                  s1_en, s2_en, s3_en;
    logic signed [PW-1:0]  prod_c;
    logic signed [SW-1:0]  sum_c;
    logic        [Y_W-1:0] q_y;
    logic                  q_ovf;

    // A stage loads when it is empty or its content moves on this cycle.
    assign s3_en = !s3_valid || bus.out_ready;
    assign s2_en = !s2_valid || s3_en;
    assign s1_en = !s1_valid || s2_en;

    assign bus.in_ready  = s1_en && !rst;
    assign bus.out_valid = s3_valid;
    assign bus.y_out     = s3_y;
    assign bus.ovf_out   = s3_ovf;

    assign prod_c = PW'($signed(bus.a_in)) * PW'($signed(bus.b_in));
    assign sum_c  = (SW'(s1_p) <<< (SF - PF)) + (SW'(s1_c) <<< (SF - C_F));

    fxp_quantize #(
        .SW    (SW),
        .SF    (SF),
        .OUT_I (OUT_I),
        .OUT_F (OUT_F)
    ) u_quantize (
        .sum      (s2_sum),
        .rnd_mode (s2_rnd),
        .sat_en   (s2_sat),
        .y_c      (q_y),
        .ovf_c    (q_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_sat   <= 1'b0;
            s1_p     <= '0;
            s1_c     <= '0;
            s2_valid <= 1'b0;
            s2_rnd   <= 1'b0;
            s2_sat   <= 1'b0;
            s2_sum   <= '0;
            s3_valid <= 1'b0;
            s3_y     <= '0;
            s3_ovf   <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_p   <= prod_c;
                    s1_c   <= $signed(bus.c_in);
                    s1_rnd <= bus.rnd_mode;
                    s1_sat <= bus.sat_en;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sum <= sum_c;
                    s2_rnd <= s1_rnd;
                    s2_sat <= s1_sat;
                end
            end
            if (s3_en) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_y   <= q_y;
                    s3_ovf <= q_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_fxp_mac_pipe.sv
// Bench for fxp_mac_pipe at default Q formats: directed vector table,
// back-pressure, mid-stream reset and a random valid/ready scoreboard run.
module tb_fxp_mac_pipe;
    localparam int unsigned A_W = 6;
    localparam int unsigned B_W = 6;
    localparam int unsigned C_W = 10;
    localparam int unsigned Y_W = 7;
    localparam int NVEC  = 14;
    localparam int NRAND = 400;

    typedef struct {
        int   a;
        int   b;
        int   c;
        logic rnd;
        logic sat;
        int   y;
        int   ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    fxp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .Y_W(Y_W)) bus ();

    fxp_mac_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input int a, input int b, input int c, input logic rnd,
                                input logic sat, input int y, input int ovf);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.rnd = rnd; v.sat = sat; v.y = y; v.ovf = ovf;
        return v;
    endfunction

    // Integer reference: A*B in Q.8, C scaled to Q.8, drop 6 LSBs, then range handling.
    function automatic void model(input vec_t v, output int y, output int ovf);
        int s;
        int q;
        s = v.a * v.b + v.c * 8;
        q = (s + (v.rnd ? 32 : 0)) >>> 6;
        ovf = (q > 63 || q < -64) ? 1 : 0;
        if (ovf == 0)      y = q;
        else if (v.sat)    y = (q > 63) ? 63 : -64;
        else               y = ((q & 127) ^ 64) - 64;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic valid);
        bus.a_in     = A_W'(v.a);
        bus.b_in     = B_W'(v.b);
        bus.c_in     = C_W'(v.c);
        bus.rnd_mode = v.rnd;
        bus.sat_en   = v.sat;
        bus.in_valid = valid;
    endtask

    // One isolated sample on an empty pipe: acceptance, 3-edge latency, result.
    task automatic send_and_check(input int i);
        int lat;
        @(posedge clk); #1;
        drive(vecs[i], 1'b1);
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", i), int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", i), lat, 3);
        chk($sformatf("v%0d_y", i), int'($signed(bus.y_out)), vecs[i].y);
        chk($sformatf("v%0d_ovf", i), int'(bus.ovf_out), vecs[i].ovf);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx;
        int   got;
        int   stale;
        int   sent;
        int   ey;
        int   eovf;
        logic acc;
        vec_t cur;
        int   exp_y[$];
        int   exp_o[$];

        vecs[0]  = mk( 12,  16,    8, 1'b0, 1'b1,   4, 0);
        vecs[1]  = mk(  1,  31,    4, 1'b0, 1'b1,   0, 0);
        vecs[2]  = mk(  1,  31,    4, 1'b1, 1'b1,   1, 0);
        vecs[3]  = mk(-32, -32,  511, 1'b0, 1'b1,  63, 1);
        vecs[4]  = mk(-32, -32,  511, 1'b0, 1'b0, -49, 1);
        vecs[5]  = mk( 31, -32, -512, 1'b0, 1'b1, -64, 1);
        vecs[6]  = mk( 31, -32, -512, 1'b0, 1'b0,  48, 1);
        vecs[7]  = mk(  0,   0,   -4, 1'b0, 1'b1,  -1, 0);
        vecs[8]  = mk(  0,   0,   -4, 1'b1, 1'b1,   0, 0);
        vecs[9]  = mk(  0,   0,    0, 1'b1, 1'b0,   0, 0);
        vecs[10] = mk(  0,   0,  504, 1'b1, 1'b1,  63, 0);
        vecs[11] = mk(  0,   0,  511, 1'b1, 1'b1,  63, 1);
        vecs[12] = mk(  0,   0,  511, 1'b1, 1'b0, -64, 1);
        vecs[13] = mk(  0,   0, -512, 1'b0, 1'b1, -64, 0);

        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(vecs[9], 1'b0);
        @(posedge clk); #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_y", int'(bus.y_out), 0);
        chk("rst_ovf", int'(bus.ovf_out), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NVEC; i++) send_and_check(i);

        // Back-pressure: only three samples fit, held output stays stable.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            drive(vecs[idx], idx < 4);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
        end
        chk("bp_accepted", idx, 3);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        chk("bp_out_valid", int'(bus.out_valid), 1);
        chk("bp_hold_y", int'($signed(bus.y_out)), vecs[0].y);
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            if (idx < 4) drive(vecs[idx], 1'b1);
            else         bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid) begin
                chk($sformatf("bp_y%0d", got), int'($signed(bus.y_out)), vecs[got].y);
                chk($sformatf("bp_ovf%0d", got), int'(bus.ovf_out), vecs[got].ovf);
                got++;
            end
        end
        chk("bp_drained", got, 4);

        // Mid-stream reset with three samples in flight.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(vecs[3 + k], 1'b1);
            @(negedge clk);
            chk($sformatf("mr_accept%0d", k), int'(bus.in_ready), 1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mr_in_ready_in_rst", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_out_valid", int'(bus.out_valid), 0);
        chk("mr_y", int'(bus.y_out), 0);
        chk("mr_ovf", int'(bus.ovf_out), 0);
        stale = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("mr_no_stale", stale, 0);
        send_and_check(2);

        // Random traffic against the integer reference, order preserved.
        @(posedge clk); #1;
        sent = 0;
        got  = 0;
        acc  = 1'b0;
        for (int cyc = 0; cyc < 8000 && got < NRAND; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (acc || !bus.in_valid) begin
                if (sent < NRAND && $urandom_range(0, 3) != 0) begin
                    cur = mk(int'($signed(A_W'($urandom))), int'($signed(B_W'($urandom))),
                             int'($signed(C_W'($urandom))), 1'($urandom), 1'($urandom), 0, 0);
                    drive(cur, 1'b1);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                model(cur, ey, eovf);
                exp_y.push_back(ey);
                exp_o.push_back(eovf);
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_y.size() == 0) begin
                    chk("rnd_unexpected_output", 1, 0);
                end else begin
                    ey   = exp_y.pop_front();
                    eovf = exp_o.pop_front();
                    chk($sformatf("rnd_y%0d", got), int'($signed(bus.y_out)), ey);
                    chk($sformatf("rnd_ovf%0d", got), int'(bus.ovf_out), eovf);
                end
                got++;
            end
        end
        chk("rnd_count", got, NRAND);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
